// File: rtl/tail_pkg.sv
// Shared types and the thermometer decode for the tail-light sequencer.
// No state; pure types and functions.
package tail_pkg;

   typedef enum logic [1:0] {M_IDLE, M_LEFT, M_RIGHT, M_HAZ} mode_t;

   // One bit of a thermometer code: lamp idx is lit while idx < step.
   function automatic logic thermo_bit(input int unsigned step, input int unsigned idx);
      return idx < step;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running step prescaler: tick is high one cycle in every TICK_DIV.
// Latency: tick is a decode of the counter; no backpressure, never restarted by requests.
module tick_gen #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

endmodule

// File: rtl/tail_light_seq.sv
// Turn/hazard sweep sequencer with brake overlay; lamps are Moore decodes of state.
// Latency: request on a tick edge lights step 1 next cycle, brake 1 clk; no backpressure.
module tail_light_seq
   import tail_pkg::*;
#(
   parameter int N_LAMPS  = 3,
   parameter int TICK_DIV = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               left,
   input  logic               right,
   input  logic               hazard,
   input  logic               brake,
   output logic [N_LAMPS-1:0] l_lamps,
   output logic [N_LAMPS-1:0] r_lamps,
   output logic               busy
);

   localparam int SW = $clog2(N_LAMPS + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(N_LAMPS);

   mode_t           mode, mode_nxt;
   logic [SW-1:0]   step, step_nxt;
   logic            brake_q;
   logic            tick;
   logic [N_LAMPS-1:0] sweep;
   logic [N_LAMPS-1:0] idle_side;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode    <= M_IDLE;
         step    <= '0;
         brake_q <= 1'b0;
      end else begin
         mode    <= mode_nxt;
         step    <= step_nxt;
         brake_q <= brake;
      end
   end

   // Requests only matter in IDLE; an active sweep always runs to the end.
   always_comb begin
      mode_nxt = mode;
      step_nxt = step;
      if (tick) begin
         case (mode)
            M_IDLE: begin
               if (hazard || (left && right)) begin
                  mode_nxt = M_HAZ;
                  step_nxt = SW'(1);
               end else if (left) begin
                  mode_nxt = M_LEFT;
                  step_nxt = SW'(1);
               end else if (right) begin
                  mode_nxt = M_RIGHT;
                  step_nxt = SW'(1);
               end
            end
            default: begin
               if (step == LAST_STEP) begin
                  mode_nxt = M_IDLE;
                  step_nxt = '0;
               end else begin
                  step_nxt = step + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < N_LAMPS; i++)
         sweep[i] = thermo_bit(int'(step), i);
   end

   assign idle_side = {N_LAMPS{brake_q}};
   assign busy      = (mode != M_IDLE);

   always_comb begin
      l_lamps = idle_side;
      r_lamps = idle_side;
      case (mode)
         M_LEFT:  l_lamps = sweep;
         M_RIGHT: r_lamps = sweep;
         M_HAZ: begin
            l_lamps = sweep;
            r_lamps = sweep;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: vector table on N=3/TICK_DIV=1 plus sequences
// for prescaler, mode lock with brake, async reset and N=8 scaling.
module tb_tail_light_seq;

   logic clk = 1'b0;
   logic reset_n, left, right, hazard, brake;

   logic [2:0] a_l, a_r;
   logic       a_busy;
   logic [2:0] p_l, p_r;
   logic       p_busy;
   logic [7:0] w_l, w_r;
   logic       w_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tail_light_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
      .brake(brake), .l_lamps(a_l), .r_lamps(a_r), .busy(a_busy));

   tail_light_seq #(.N_LAMPS(3), .TICK_DIV(4)) dut_p (
      .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
      .brake(brake), .l_lamps(p_l), .r_lamps(p_r), .busy(p_busy));

   tail_light_seq #(.N_LAMPS(8), .TICK_DIV(1)) dut_w (
      .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
      .brake(brake), .l_lamps(w_l), .r_lamps(w_r), .busy(w_busy));

   typedef struct {
      logic       left, right, hazard, brake;
      logic [2:0] l, r;
      logic       busy;
   } vec_t;

   vec_t vecs[27];

   task automatic check(input string name, input int idx, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic set_in(input logic l, input logic r, input logic h, input logic b);
      left = l; right = r; hazard = h; brake = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      set_in(0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(0, 0, 0, 0);

      vecs[0]  = '{1,0,0,0, 3'b001, 3'b000, 1};
      vecs[1]  = '{1,0,0,0, 3'b011, 3'b000, 1};
      vecs[2]  = '{1,0,0,0, 3'b111, 3'b000, 1};
      vecs[3]  = '{1,0,0,0, 3'b000, 3'b000, 0};
      vecs[4]  = '{1,0,0,0, 3'b001, 3'b000, 1};
      vecs[5]  = '{0,0,0,0, 3'b011, 3'b000, 1};
      vecs[6]  = '{0,0,0,0, 3'b111, 3'b000, 1};
      vecs[7]  = '{0,0,0,0, 3'b000, 3'b000, 0};
      vecs[8]  = '{1,1,0,0, 3'b001, 3'b001, 1};
      vecs[9]  = '{1,1,0,0, 3'b011, 3'b011, 1};
      vecs[10] = '{1,1,0,0, 3'b111, 3'b111, 1};
      vecs[11] = '{0,0,0,0, 3'b000, 3'b000, 0};
      vecs[12] = '{0,0,1,0, 3'b001, 3'b001, 1};
      vecs[13] = '{0,0,0,0, 3'b011, 3'b011, 1};
      vecs[14] = '{0,0,0,0, 3'b111, 3'b111, 1};
      vecs[15] = '{0,0,0,0, 3'b000, 3'b000, 0};
      vecs[16] = '{0,0,0,1, 3'b111, 3'b111, 0};
      vecs[17] = '{0,0,0,0, 3'b000, 3'b000, 0};
      vecs[18] = '{0,1,0,0, 3'b000, 3'b001, 1};
      vecs[19] = '{0,0,0,1, 3'b111, 3'b011, 1};
      vecs[20] = '{0,0,0,1, 3'b111, 3'b111, 1};
      vecs[21] = '{0,0,0,0, 3'b000, 3'b000, 0};
      vecs[22] = '{0,0,1,1, 3'b001, 3'b001, 1};
      vecs[23] = '{0,0,0,1, 3'b011, 3'b011, 1};
      vecs[24] = '{0,0,0,1, 3'b111, 3'b111, 1};
      vecs[25] = '{0,0,0,1, 3'b111, 3'b111, 0};
      vecs[26] = '{0,0,0,0, 3'b000, 3'b000, 0};

      // Reset state with no clock edge seen yet
      #1;
      check("rst_a_l", 0, 16'(a_l), 16'h0);
      check("rst_a_r", 0, 16'(a_r), 16'h0);
      check("rst_a_busy", 0, 16'(a_busy), 16'h0);
      check("rst_w_l", 0, 16'(w_l), 16'h0);
      check("rst_p_busy", 0, 16'(p_busy), 16'h0);

      // Table: N=3, TICK_DIV=1
      do_reset();
      for (int i = 0; i < 27; i++) begin
         set_in(vecs[i].left, vecs[i].right, vecs[i].hazard, vecs[i].brake);
         @(negedge clk);
         check("vec_l", i, 16'(a_l), 16'(vecs[i].l));
         check("vec_r", i, 16'(a_r), 16'(vecs[i].r));
         check("vec_busy", i, 16'(a_busy), 16'(vecs[i].busy));
      end

      // Prescaler: TICK_DIV=4, right held 4 cycles from reset release
      do_reset();
      set_in(0, 1, 0, 0);
      for (int c = 1; c <= 20; c++) begin
         logic [2:0] er;
         @(negedge clk);
         if (c < 4)       er = 3'b000;
         else if (c < 8)  er = 3'b001;
         else if (c < 12) er = 3'b011;
         else if (c < 16) er = 3'b111;
         else             er = 3'b000;
         check("pre_r", c, 16'(p_r), 16'(er));
         check("pre_l", c, 16'(p_l), 16'h0);
         check("pre_busy", c, 16'(p_busy), 16'(er != 3'b000));
         if (c == 4) right = 1'b0;
      end

      // Mode lock plus brake: right and brake arrive during a left sweep
      do_reset();
      set_in(1, 0, 0, 0);
      @(negedge clk);
      check("lock_l", 1, 16'(a_l), 16'h1);
      set_in(0, 1, 0, 1);
      @(negedge clk);
      check("lock_l", 2, 16'(a_l), 16'h3);
      check("lock_r", 2, 16'(a_r), 16'h7);
      @(negedge clk);
      check("lock_l", 3, 16'(a_l), 16'h7);
      check("lock_r", 3, 16'(a_r), 16'h7);
      set_in(0, 0, 0, 1);
      for (int c = 4; c <= 5; c++) begin
         @(negedge clk);
         check("lock_l", c, 16'(a_l), 16'h7);
         check("lock_r", c, 16'(a_r), 16'h7);
         check("lock_busy", c, 16'(a_busy), 16'h0);
      end

      // Async reset at step 2 of a hazard sweep
      do_reset();
      set_in(0, 0, 1, 0);
      @(negedge clk);
      hazard = 1'b0;
      @(negedge clk);
      check("ar_pre_l", 0, 16'(a_l), 16'h3);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_l", 0, 16'(a_l), 16'h0);
      check("ar_r", 0, 16'(a_r), 16'h0);
      check("ar_busy", 0, 16'(a_busy), 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("ar_post_lr", c, {8'(a_l), 8'(a_r)}, 16'h0);
         check("ar_post_busy", c, 16'(a_busy), 16'h0);
      end

      // Width scaling: N=8 left, period 9
      do_reset();
      set_in(1, 0, 0, 0);
      for (int c = 1; c <= 18; c++) begin
         int k;
         logic [15:0] el;
         @(negedge clk);
         k  = ((c - 1) % 9) + 1;
         el = (k <= 8) ? 16'((16'd1 << k) - 16'd1) : 16'h0;
         check("wide_l", c, 16'(w_l), el);
         check("wide_r", c, 16'(w_r), 16'h0);
         check("wide_busy", c, 16'(w_busy), 16'(k <= 8));
      end
      set_in(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Parametrised turn-signal/hazard sequencer for the tail-light subsystem. Drives N lamps per side with a thermometer "sweep" pattern for left, right and hazard requests. Adds a programmable step prescaler and a brake overlay that lights every idle-side lamp. Sits between the debounced switch inputs and the lamp output drivers.

## Interface
- N_LAMPS, 3, lamps per side; legal range 1..16; bit 0 is the innermost lamp (A), bit N_LAMPS-1 the outermost (C).
- TICK_DIV, 1, clock cycles per sequence step; legal value ≥1; 1 means one step per clock.
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- l_lamps  out  N_LAMPS  left lamp drive, 1 = on.
- r_lamps  out  N_LAMPS  right lamp drive, 1 = on.
- busy  out  1  high while a sequence is in progress (mode ≠ IDLE).

## Operation
- Modes: IDLE, LEFT, RIGHT, HAZ. Step counter `step` runs 0..N_LAMPS; 0 only in IDLE.
- Tick: free-running prescaler `div_cnt` counts 0..TICK_DIV-1 and wraps; tick = (div_cnt == TICK_DIV-1). With TICK_DIV=1, tick is constantly 1. The prescaler is not restarted by requests.
- Mode/step advance only on tick cycles. On non-tick cycles they hold.
- IDLE on tick; priority is top to bottom:
  - hazard=1, or left=1 and right=1 -> HAZ, step=1.
  - left=1 -> LEFT, step=1.
  - right=1 -> RIGHT, step=1.
  - otherwise stay in IDLE.
- LEFT/RIGHT/HAZ on tick:
  - step<N_LAMPS -> step+1.
  - step==N_LAMPS -> IDLE, step=0.
- Sequences always run to completion. Request inputs are ignored outside IDLE, so a mode cannot be switched or aborted mid-sweep.
- Sweep pattern: thermometer of width N_LAMPS with the low `step` bits set. step=2, N=3 gives 3'b011.
- Lamp decode:
  - LEFT: l_lamps = sweep.
  - RIGHT: r_lamps = sweep.
  - HAZ: both sides = sweep.
  - Any side not being swept = all-ones if brake_q, else zero.
- HAZ ignores brake_q entirely.
- brake_q: brake registered every clk (not tick-gated).
- Continuous left with TICK_DIV=1 repeats with period N_LAMPS+1 cycles: N lit steps plus one dark IDLE cycle.

## Timing
- Reset (reset_n=0, asynchronous): mode=IDLE, step=0, div_cnt=0, brake_q=0. Outputs l_lamps=0, r_lamps=0, busy=0 within the reset assertion, with no clock required.
- Reset asserted mid-sequence: lamps go dark immediately. The first request after release is evaluated at the first tick.
- Request latency: a request sampled on a tick edge shows step=1 lamps in the following cycle.
- Brake latency: exactly 1 clk from brake to lamps, independent of tick.
- Outputs are combinational decodes of registered state only (Moore); no input-to-output combinational path.
- Simultaneous left+right counts as a hazard request. A request that rises and falls entirely between ticks is missed, by design.

## Structure
- Package tail_pkg holds `typedef enum logic [1:0] {M_IDLE, M_LEFT, M_RIGHT, M_HAZ} mode_t` and the thermometer-decode function.
- Sub-module tick_gen, parameter TICK_DIV, ports clk/reset_n/tick: the prescaler.
- The sequencer FSM and lamp decode live in tail_light_seq.

## Test plan
- Left sweep: N=3, TICK_DIV=1, reset, then hold left=1 -> l_lamps 001, 011, 111, 000, 001… on consecutive cycles; r_lamps=000 throughout; busy low only on the 000 cycle.
- Hazard: left=right=1, N=3 -> both sides 001, 011, 111, 000. Repeat with hazard=1 alone and get the identical pattern.
- Prescaler: TICK_DIV=4, N=3, right pulsed high for 4 cycles -> each r_lamps value (001, 011, 111) held 4 cycles, then 000; no second sweep.
- Mode lock plus brake: start a left sweep, then at step 1 assert right and brake -> left finishes 011, 111 unchanged; r_lamps=111 from 1 clk after brake rose; after return to IDLE with brake high, both sides read 111.
- Async reset: assert reset_n=0 mid-cycle at step 2 of HAZ -> lamps 0 and busy 0 before the next clk edge; after release, with no requests, lamps stay 0.
- Width scaling: N=8, TICK_DIV=1, left -> 8 steps 0x01, 0x03, … 0xFF, then 0x00; period 9 cycles.
